pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Sequences the system clock PLL and the resets of the domains it clocks. The block pulses the PLL reset, waits for `locked` to be stable, then releases the per-domain resets in a fixed staggered order. On loss of lock or a software relock request it re-asserts every domain reset and restarts the sequence. It sits in the `refclk` domain beside the PLL wrapper and feeds the reset synchronizers of the 28/25/14 MHz domains.

## Interface

Parameters:
- `PLL_RST_CYCLES`, 16: length of the `pll_rst` pulse in cycles (minimum 1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before any release (minimum 1).
- `NUM_DOMAINS`, 3: number of staged domain resets (minimum 1).
- `STAGE_GAP`, 8: cycles between successive domain releases (minimum 1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry.

Ports:
- `refclk`, in, 1: the block's only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `locked_i`, in, 1: PLL `locked`, asynchronous; synchronized internally.
- `relock_req`, in, 1: single-cycle request to restart the PLL.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `domain_rst_n`, out, NUM_DOMAINS: active-low domain resets; index 0 is released first.
- `ready`, out, 1: high once all domains are released and lock holds.
- `timeout_err`, out, 1: sticky; set on a lock timeout, cleared by `relock_req`.
- `lock_loss_cnt`, out, 8: saturating count of lock losses seen in RELEASE or RUN.

## Operation

- Reset values:
  - `pll_rst`=1, `domain_rst_n`=all 0, `ready`=0, `timeout_err`=0, `lock_loss_cnt`=0.
  - The FSM resets to RESET_PLL.
- `locked_i` passes through a 2-flop synchronizer to produce `lock_s`. The synchronizer flops reset to 0.
- FSM states:
  - RESET_PLL: `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1: go to STABLE with the counter cleared.
    - LOCK_TIMEOUT cycles without lock: set `timeout_err` and go to RESET_PLL.
  - STABLE: count consecutive cycles with `lock_s`=1.
    - `lock_s`=0: go to WAIT_LOCK. Do not increment `lock_loss_cnt`.
    - Count reaches LOCK_STABLE_CYCLES: go to RELEASE.
  - RELEASE: deassert `domain_rst_n[i]` at RELEASE entry + i*STAGE_GAP cycles. Go to RUN on the cycle after the last domain is released.
  - RUN: `ready`=1.
- Lock loss (`lock_s`=0) in RELEASE or RUN:
  - Registered on the next edge: all `domain_rst_n`=0 and `ready`=0.
  - `lock_loss_cnt` increments, saturating at 255.
  - Go to RESET_PLL.
- `relock_req`:
  - In any state other than RESET_PLL: same actions as a lock loss, except the counter does not increment.
  - In RESET_PLL: ignored; the pulse count continues.
  - Always clears `timeout_err`. If a timeout occurs in the same cycle, set wins.
- Simultaneous lock loss and `relock_req`: one event, and the counter increments once.
- Domain resets are only ever released in ascending index order. Assertion is always simultaneous for all domains.
- Counter widths are `$clog2` of the largest compare value plus 1. Counters never wrap.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- `locked_i` to `lock_s` latency: 2 cycles.
- Let `locked_i` rise before edge k, with the FSM already in WAIT_LOCK:
  - `lock_s` is high from edge k+2 and the FSM enters STABLE.
  - `domain_rst_n[0]` rises at edge k+2+LOCK_STABLE_CYCLES.
  - `domain_rst_n[i]` rises STAGE_GAP*i cycles after `domain_rst_n[0]`.
  - `ready` rises 1 cycle after the last release.
- `rst_n` assertion mid-sequence: all outputs take their reset values immediately (asynchronously). Release is synchronous to `refclk`.

## Structure

- The package `pll_seq_pkg` holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN);
  - the default parameter constants;
  - the `lock_loss_cnt` width.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with async active-low reset, used for `locked_i`.
- Everything else is in one FSM plus a shared down-counter and a stage index register.

## Test plan

All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, STAGE_GAP=2, NUM_DOMAINS=3, LOCK_TIMEOUT=32.

1. Normal bring-up: release `rst_n`; raise `locked_i` before edge 10.
   - `pll_rst` is high for 4 cycles.
   - `domain_rst_n` goes 001 at edge 20, 011 at 22, 111 at 24.
   - `ready`=1 at 25.
2. Lock glitch in STABLE: drop `locked_i` for 1 cycle, 5 cycles into STABLE.
   - The stable count restarts; no release occurs before 8 fresh lock cycles.
   - `lock_loss_cnt`=0.
3. Lock loss in RUN: drop `locked_i`.
   - Within 3 cycles: `domain_rst_n`=000, `ready`=0, `lock_loss_cnt`=1, `pll_rst`=1 for 4 cycles.
   - The full sequence then repeats.
4. Timeout: keep `locked_i`=0.
   - `timeout_err`=1 after 4+32 cycles, followed by a new 4-cycle `pll_rst` pulse.
   - A subsequent `relock_req` clears `timeout_err`.
5. `relock_req` in RUN together with a lock drop: a single restart and `lock_loss_cnt` +1 only. Separately, `relock_req` during RESET_PLL does not extend the pulse beyond 4 cycles.
6. Saturation and async reset:
   - 256 lock losses leave `lock_loss_cnt`=255.
   - `rst_n` low during RELEASE forces all reset values immediately.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } seq_state_e;

   localparam int DEF_PLL_RST_CYCLES     = 16;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_NUM_DOMAINS        = 3;
   localparam int DEF_STAGE_GAP          = 8;
   localparam int DEF_LOCK_TIMEOUT       = 65536;

   localparam int LOSS_CNT_W = 8;

   // Largest of four compare values; sizes the shared down-counter.
   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer, flops clear to 0 on reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         // NOTE: non-blocking so q takes the old meta, giving two real stages.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, waits for stable lock, then
// releases domain resets in ascending order; restarts on lock loss or relock.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
   parameter int STAGE_GAP          = DEF_STAGE_GAP,
   parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   input  logic                   locked_i,
   input  logic                   relock_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   ready,
   output logic                   timeout_err,
   output logic [LOSS_CNT_W-1:0]  lock_loss_cnt
);

   localparam int CNT_W = $clog2(max_of4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                         STAGE_GAP, LOCK_TIMEOUT)) + 1;
   localparam int STG_W = $clog2(NUM_DOMAINS) + 1;

   logic lock_s;

   seq_state_e             state, state_next;
   logic [CNT_W-1:0]       cnt, cnt_next;
   logic [STG_W-1:0]       stage, stage_next;
   logic                   pll_rst_next;
   logic [NUM_DOMAINS-1:0] domain_rst_n_next;
   logic                   ready_next;
   logic                   timeout_next;
   logic [LOSS_CNT_W-1:0]  loss_next;
   logic                   timeout_hit;
   logic                   lock_lost;
   logic                   restart;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (locked_i),
      .q     (lock_s)
   );

   // State, shared counter, stage index and all registered outputs.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RESET_PLL;
         cnt           <= CNT_W'(PLL_RST_CYCLES - 1);
         stage         <= '0;
         pll_rst       <= 1'b1;
         domain_rst_n  <= '0;
         ready         <= 1'b0;
         timeout_err   <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         stage         <= stage_next;
         pll_rst       <= pll_rst_next;
         domain_rst_n  <= domain_rst_n_next;
         ready         <= ready_next;
         timeout_err   <= timeout_next;
         lock_loss_cnt <= loss_next;
      end
   end

   // Next-state and next-output logic; counter loads value-1 and counts to 0.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves a latch.
      state_next        = state;
      cnt_next          = cnt;
      stage_next        = stage;
      pll_rst_next      = pll_rst;
      domain_rst_n_next = domain_rst_n;
      ready_next        = ready;
      timeout_next      = timeout_err;
      loss_next         = lock_loss_cnt;
      timeout_hit       = 1'b0;
      lock_lost         = 1'b0;
      restart           = 1'b0;

      case (state)
         RESET_PLL: begin
            if (cnt == '0) begin
               state_next   = WAIT_LOCK;
               pll_rst_next = 1'b0;
               cnt_next     = CNT_W'(LOCK_TIMEOUT - 1);
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_next = STABLE;
               cnt_next   = CNT_W'(LOCK_STABLE_CYCLES - 1);
            end else if (cnt == '0) begin
               timeout_hit = 1'b1;
               restart     = 1'b1;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         STABLE: begin
            if (!lock_s) begin
               // A glitch here is not counted as a loss; just wait again.
               state_next = WAIT_LOCK;
               cnt_next   = CNT_W'(LOCK_TIMEOUT - 1);
            end else if (cnt == '0) begin
               state_next           = RELEASE;
               domain_rst_n_next[0] = 1'b1;
               stage_next           = STG_W'(1);
               cnt_next             = CNT_W'(STAGE_GAP - 1);
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RELEASE: begin
            if (stage == STG_W'(NUM_DOMAINS)) begin
               state_next = RUN;
               ready_next = 1'b1;
            end else if (cnt == '0) begin
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  if (stage == STG_W'(i)) domain_rst_n_next[i] = 1'b1;
               end
               stage_next = stage + STG_W'(1);
               cnt_next   = CNT_W'(STAGE_GAP - 1);
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RUN: begin
            ready_next = 1'b1;
         end
         default: begin
            restart = 1'b1;
         end
      endcase

      lock_lost = ((state == RELEASE) || (state == RUN)) && !lock_s;
      if (lock_lost) begin
         restart = 1'b1;
         if (lock_loss_cnt != '1) loss_next = lock_loss_cnt + LOSS_CNT_W'(1);
      end

      // Relock merges with a coincident lock loss into one restart.
      if (relock_req && (state != RESET_PLL)) restart = 1'b1;

      if (restart) begin
         state_next        = RESET_PLL;
         cnt_next          = CNT_W'(PLL_RST_CYCLES - 1);
         stage_next        = '0;
         pll_rst_next      = 1'b1;
         domain_rst_n_next = '0;
         ready_next        = 1'b0;
      end

      // Timeout set takes priority over the relock clear.
      if (timeout_hit)     timeout_next = 1'b1;
      else if (relock_req) timeout_next = 1'b0;
   end

endmodule
